// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: RISC-V load/store funct3
// encodings, arbiter FSM states and the access-alignment check.
package mem_arbiter_pkg;

  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;
  localparam logic [2:0] FNC_SB  = 3'b000;
  localparam logic [2:0] FNC_SH  = 3'b001;
  localparam logic [2:0] FNC_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_IF = 2'd1,
    ST_WAIT_DM = 2'd2,
    ST_ERR     = 2'd3
  } state_e;

  // Unknown encodings are sized as a word, matching their LW/SW treatment.
  function automatic logic is_misaligned(input logic we, input logic [2:0] funct3,
                                         input logic [1:0] off);
    logic [1:0] size;
    if (we) begin
      case (funct3)
        FNC_SB:  size = 2'd0;
        FNC_SH:  size = 2'd1;
        default: size = 2'd2;
      endcase
    end else begin
      case (funct3)
        FNC_LB, FNC_LBU: size = 2'd0;
        FNC_LH, FNC_LHU: size = 2'd1;
        default:         size = 2'd2;
      endcase
    end
    case (size)
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_load_extend.sv
// Load lane select and sign/zero extension of a memory word.
module load_extend
  import mem_arbiter_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  lane_byte_s;
  logic [15:0] lane_half_s;

  // Pick the addressed byte/half, then extend according to the load type.
  always_comb begin
    case (off_i)
      2'd0:    lane_byte_s = word_i[7:0];
      2'd1:    lane_byte_s = word_i[15:8];
      2'd2:    lane_byte_s = word_i[23:16];
      default: lane_byte_s = word_i[31:24];
    endcase
    lane_half_s = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      FNC_LB:  data_o = {{24{lane_byte_s[7]}}, lane_byte_s};
      FNC_LH:  data_o = {{16{lane_half_s[15]}}, lane_half_s};
      FNC_LBU: data_o = {24'h000000, lane_byte_s};
      FNC_LHU: data_o = {16'h0000, lane_half_s};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported memory between instruction fetch and load/store,
// DM first with a starvation guard for IF; one access outstanding at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AWIDTH     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [AWIDTH-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_resp_valid,
  output logic [31:0]       if_resp_data,
  input  logic              dm_req_valid,
  input  logic              dm_req_we,
  input  logic [2:0]        dm_req_funct3,
  input  logic [AWIDTH-1:0] dm_req_addr,
  input  logic [31:0]       dm_req_wdata,
  output logic              dm_req_ready,
  output logic              dm_resp_valid,
  output logic [31:0]       dm_resp_data,
  output logic              dm_resp_err,
  output logic              mem_req_valid,
  output logic [AWIDTH-1:0] mem_req_addr,
  output logic              mem_req_we,
  output logic [3:0]        mem_req_wmask,
  output logic [31:0]       mem_req_wdata,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  state_e      state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic        if_rvalid_q, if_rvalid_d, dm_rvalid_q, dm_rvalid_d, dm_err_q, dm_err_d;
  logic [31:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        we_q, we_d;

  logic        if_ready_s, dm_ready_s, mem_valid_s, dm_grant_s, if_hs_s, dm_win_s, dm_mis_s;
  logic [31:0] ext_data_s;
  logic        unused_addr_s;

  assign unused_addr_s = ^if_req_addr[1:0];
  assign dm_mis_s = is_misaligned(dm_req_we, dm_req_funct3, dm_req_addr[1:0]);
  assign dm_win_s = dm_req_valid && !(if_req_valid && (starve_q == STARVE_LIM));

  load_extend u_load_extend (
    .funct3_i (f3_q),
    .off_i    (off_q),
    .word_i   (mem_resp_data),
    .data_o   (ext_data_s)
  );

  // Arbitration, memory request drive, response capture and next state.
  always_comb begin
    state_d       = state_q;
    if_rvalid_d   = 1'b0;
    dm_rvalid_d   = 1'b0;
    dm_err_d      = 1'b0;
    if_rdata_d    = if_rdata_q;
    dm_rdata_d    = dm_rdata_q;
    f3_d          = f3_q;
    off_d         = off_q;
    we_d          = we_q;
    if_ready_s    = 1'b0;
    dm_ready_s    = 1'b0;
    mem_valid_s   = 1'b0;
    mem_req_addr  = '0;
    mem_req_we    = 1'b0;
    mem_req_wmask = 4'b0000;
    mem_req_wdata = 32'h0000_0000;
    dm_grant_s    = 1'b0;
    if_hs_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dm_win_s && dm_mis_s) begin
          dm_ready_s  = 1'b1;
          dm_grant_s  = 1'b1;
          dm_rvalid_d = 1'b1;
          dm_err_d    = 1'b1;
          dm_rdata_d  = 32'h0000_0000;
          state_d     = ST_ERR;
        end else if (dm_win_s) begin
          mem_valid_s  = 1'b1;
          mem_req_addr = {dm_req_addr[AWIDTH-1:2], 2'b00};
          mem_req_we   = dm_req_we;
          if (dm_req_we) begin
            case (dm_req_funct3)
              FNC_SB: begin
                mem_req_wmask = 4'b0001 << dm_req_addr[1:0];
                mem_req_wdata = {4{dm_req_wdata[7:0]}};
              end
              FNC_SH: begin
                mem_req_wmask = 4'b0011 << dm_req_addr[1:0];
                mem_req_wdata = {2{dm_req_wdata[15:0]}};
              end
              default: begin
                mem_req_wmask = 4'b1111;
                mem_req_wdata = dm_req_wdata;
              end
            endcase
          end else begin
            mem_req_wmask = 4'b0000;
            mem_req_wdata = 32'h0000_0000;
          end
          dm_ready_s = mem_req_ready;
          if (mem_req_ready) begin
            dm_grant_s = 1'b1;
            f3_d       = dm_req_funct3;
            off_d      = dm_req_addr[1:0];
            we_d       = dm_req_we;
            state_d    = ST_WAIT_DM;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (if_req_valid) begin
          mem_valid_s  = 1'b1;
          mem_req_addr = {if_req_addr[AWIDTH-1:2], 2'b00};
          if_ready_s   = mem_req_ready;
          if (mem_req_ready) begin
            if_hs_s = 1'b1;
            state_d = ST_WAIT_IF;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_IF: begin
        if (mem_resp_valid) begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_resp_data;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_WAIT_IF;
        end
      end
      ST_WAIT_DM: begin
        if (mem_resp_valid) begin
          dm_rvalid_d = 1'b1;
          dm_rdata_d  = we_q ? 32'h0000_0000 : ext_data_s;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DM;
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (!if_req_valid || if_hs_s) begin
      starve_d = '0;
    end else if (dm_grant_s && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + CW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Handshakes are suppressed while reset is held.
  assign mem_req_valid = mem_valid_s && !rst;
  assign if_req_ready  = if_ready_s && !rst;
  assign dm_req_ready  = dm_ready_s && !rst;

  assign if_resp_valid = if_rvalid_q;
  assign if_resp_data  = if_rdata_q;
  assign dm_resp_valid = dm_rvalid_q;
  assign dm_resp_data  = dm_rdata_q;
  assign dm_resp_err   = dm_err_q;

  // State and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      dm_err_q    <= 1'b0;
      if_rdata_q  <= 32'h0000_0000;
      dm_rdata_q  <= 32'h0000_0000;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      dm_err_q    <= dm_err_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      we_q        <= we_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single DM accesses plus
// hand-written reset, stall and starvation sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready, if_resp_valid;
  logic [31:0] if_resp_data;
  logic        dm_req_valid, dm_req_we;
  logic [2:0]  dm_req_funct3;
  logic [31:0] dm_req_addr, dm_req_wdata;
  logic        dm_req_ready, dm_resp_valid, dm_resp_err;
  logic [31:0] dm_resp_data;
  logic        mem_req_valid, mem_req_we, mem_req_ready, mem_resp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_data;
  logic [3:0]  mem_req_wmask;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AWIDTH(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .dm_req_valid(dm_req_valid), .dm_req_we(dm_req_we), .dm_req_funct3(dm_req_funct3),
    .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata), .dm_req_ready(dm_req_ready),
    .dm_resp_valid(dm_resp_valid), .dm_resp_data(dm_resp_data), .dm_resp_err(dm_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
    .mem_req_wmask(mem_req_wmask), .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rword;
    logic        mis;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_mwdata;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    dm_req_valid   = 1'b1;
    dm_req_we      = v.we;
    dm_req_funct3  = v.f3;
    dm_req_addr    = v.addr;
    dm_req_wdata   = v.wdata;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    #1;
    check($sformatf("v%0d dm_req_ready", idx), {31'd0, dm_req_ready}, 32'd1);
    if (v.mis) begin
      check($sformatf("v%0d mem_req_valid(mis)", idx), {31'd0, mem_req_valid}, 32'd0);
    end else begin
      check($sformatf("v%0d mem_req_valid", idx), {31'd0, mem_req_valid}, 32'd1);
      check($sformatf("v%0d mem_req_addr", idx), mem_req_addr, v.exp_maddr);
      check($sformatf("v%0d mem_req_we", idx), {31'd0, mem_req_we}, {31'd0, v.we});
      check($sformatf("v%0d mem_req_wmask", idx), {28'd0, mem_req_wmask}, {28'd0, v.exp_mask});
      if (v.we) check($sformatf("v%0d mem_req_wdata", idx), mem_req_wdata, v.exp_mwdata);
    end
    @(posedge clk);
    @(negedge clk);
    dm_req_valid = 1'b0;
    if (v.mis) begin
      #1;
      check($sformatf("v%0d err resp_valid", idx), {31'd0, dm_resp_valid}, 32'd1);
      check($sformatf("v%0d err resp_err", idx), {31'd0, dm_resp_err}, 32'd1);
      check($sformatf("v%0d err resp_data", idx), dm_resp_data, 32'd0);
    end else begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = v.rword;
      #1;
      check($sformatf("v%0d resp_valid early", idx), {31'd0, dm_resp_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      mem_resp_valid = 1'b0;
      #1;
      check($sformatf("v%0d resp_valid", idx), {31'd0, dm_resp_valid}, 32'd1);
      check($sformatf("v%0d resp_data", idx), dm_resp_data, v.exp_data);
      check($sformatf("v%0d resp_err", idx), {31'd0, dm_resp_err}, 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    check($sformatf("v%0d resp_valid pulse", idx), {31'd0, dm_resp_valid}, 32'd0);
  endtask

  logic exp_if_grant[6];

  initial begin
    //          we    f3      addr          wdata         rword         mis   maddr         mask     mwdata        data
    vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_0000, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FF80};
    vecs[2]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_0000, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_0080};
    vecs[3]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_0000, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_80FF};
    vecs[4]  = '{1'b1, 3'b001, 32'h0000_00A2, 32'h1234_ABCD, 32'h5555_5555, 1'b0, 32'h0000_00A0, 4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[5]  = '{1'b1, 3'b010, 32'h0000_00A1, 32'h1111_2222, 32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
    vecs[6]  = '{1'b1, 3'b000, 32'h0000_00A1, 32'hFFFF_FF5A, 32'h7777_7777, 1'b0, 32'h0000_00A0, 4'b0010, 32'h5A5A_5A5A, 32'h0};
    vecs[7]  = '{1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h8001_1234, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_8001};
    vecs[8]  = '{1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
    vecs[9]  = '{1'b0, 3'b011, 32'h0000_0104, 32'h0,        32'h0123_4567, 1'b0, 32'h0000_0104, 4'b0000, 32'h0,        32'h0123_4567};
    vecs[10] = '{1'b1, 3'b111, 32'h0000_0108, 32'hCAFE_F00D, 32'h0,        1'b0, 32'h0000_0108, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[11] = '{1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_7F00, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_007F};
    exp_if_grant = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    if_req_valid = 1'b0; if_req_addr = 32'h0000_1000;
    dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_funct3 = 3'b010;
    dm_req_addr = 32'h0000_0100; dm_req_wdata = 32'h0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'h0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("reset mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("reset dm_req_ready", {31'd0, dm_req_ready}, 32'd0);
    check("reset dm_resp_valid", {31'd0, dm_resp_valid}, 32'd0);
    check("reset if_resp_valid", {31'd0, if_resp_valid}, 32'd0);
    check("reset dm_resp_err", {31'd0, dm_resp_err}, 32'd0);
    check("reset dm_resp_data", dm_resp_data, 32'd0);
    check("reset if_resp_data", if_resp_data, 32'd0);
    dm_req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mem_resp_valid = 1'b0;

    // stale response in IDLE is ignored
    @(negedge clk);
    mem_resp_valid = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    check("stale resp ignored", {31'd0, dm_resp_valid | if_resp_valid}, 32'd0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // memory back-pressure in IDLE stalls without state change
    @(negedge clk);
    dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_funct3 = 3'b010;
    dm_req_addr = 32'h0000_0200; mem_req_ready = 1'b0;
    #1;
    check("stall mem_req_valid", {31'd0, mem_req_valid}, 32'd1);
    check("stall dm_req_ready", {31'd0, dm_req_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("stall held valid", {31'd0, mem_req_valid}, 32'd1);
    check("stall held addr", mem_req_addr, 32'h0000_0200);
    dm_req_valid = 1'b0; mem_req_ready = 1'b1;
    #1;
    check("stall idle release", {31'd0, mem_req_valid}, 32'd0);

    // reset while in WAIT_DM drops the outstanding response
    @(negedge clk);
    dm_req_valid = 1'b1; dm_req_addr = 32'h0000_0300;
    @(posedge clk);
    @(negedge clk);
    dm_req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h1234_5678;
    #1;
    check("rst wait resp_valid", {31'd0, dm_resp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    check("rst stale resp_valid", {31'd0, dm_resp_valid}, 32'd0);
    run_vec(vecs[0], 100);

    // continuous IF and DM traffic: four DM grants, then IF is forced
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 32'h0000_1003;
    dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_funct3 = 3'b010;
    dm_req_addr = 32'h0000_0200; mem_req_ready = 1'b1;
    mem_resp_data = 32'h0000_0013;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(negedge clk);
        mem_resp_valid = 1'b0;
      end
      #1;
      check($sformatf("grant%0d if_req_ready", i), {31'd0, if_req_ready}, {31'd0, exp_if_grant[i]});
      check($sformatf("grant%0d dm_req_ready", i), {31'd0, dm_req_ready}, {31'd0, ~exp_if_grant[i]});
      if (exp_if_grant[i]) check($sformatf("grant%0d if addr", i), mem_req_addr, 32'h0000_1000);
      if (i > 0) begin
        check($sformatf("grant%0d prev if_resp", i), {31'd0, if_resp_valid}, {31'd0, exp_if_grant[i-1]});
        check($sformatf("grant%0d prev dm_resp", i), {31'd0, dm_resp_valid}, {31'd0, ~exp_if_grant[i-1]});
        if (exp_if_grant[i-1]) check("if_resp_data", if_resp_data, 32'h0000_0013);
      end
      @(posedge clk);
      @(negedge clk);
      mem_resp_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    if_req_valid = 1'b0;
    dm_req_valid = 1'b0;
    #1;
    check("grant last dm_resp", {31'd0, dm_resp_valid}, 32'd1);
    @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
